menu_nav_fsm: RTL and testbench
===============================

// Module: menu_nav_fsm
// PURPOSE
//   Parametrised top-level menu controller: N_ITEMS selectable entries navigated by up/down with
//   wrap-around and auto-repeat, entered by right, aborted by left or finished by game_done.
//   Sits between the Button debouncers and the game/VGA blocks; drives item selects and a status code.
//   Last item is optionally a terminal EXIT entry.
// PARAMETERS
//   N_ITEMS       3   number of menu entries (>=2); IDX_W = $clog2(N_ITEMS) (localparam)
//   EXIT_LAST     1   1: entering item N_ITEMS-1 goes to HALT; 0: it is an ordinary game
//   RETURN_TO_SEL 1   1: return from game to the item that was entered; 0: return to item 0
//   REPEAT_DLY    0   cycles up/down must be held before first auto-repeat step; 0 = auto-repeat off
//   REPEAT_PER    1   cycles between subsequent auto-repeat steps (>=1)
// PORTS
//   sys_clk       in   1        system clock
//   sys_rst_n     in   1        asynchronous reset, active low
//   btn_up        in   1        debounced level, previous item
//   btn_down      in   1        debounced level, next item
//   btn_left      in   1        debounced level, abort running game
//   btn_right     in   1        debounced level, enter/confirm
//   game_done     in   1        1-cycle pulse from the running game: finished
//   menu_idx      out  IDX_W    highlighted / active item
//   in_game       out  1        high while in GAME
//   halted        out  1        high while in HALT
//   game_sel      out  N_ITEMS  one-hot of active game; all zero unless in GAME
//   enter_pulse   out  1        one cycle on every MENU->GAME transition
//   state_output  out  IDX_W+2  {halted, in_game, menu_idx}
// BEHAVIOUR
//   - All outputs registered. Reset: state MENU, menu_idx 0, in_game 0, halted 0, game_sel 0,
//     enter_pulse 0, edge-detect history 0, repeat counter 0. Reset mid-game/halt returns here.
//   - Edge detect: evt_x = btn_x & ~btn_x_q. Level first sampled high at edge k -> outputs change
//     after edge k (latency 1 clock from input to output). Held level gives no further events
//     except auto-repeat.
//   - States: MENU, GAME, HALT.
//   - MENU: evt_up & evt_down same cycle -> no action at all. Else priority down > up > right.
//     down: idx = (idx==N_ITEMS-1) ? 0 : idx+1. up: idx = (idx==0) ? N_ITEMS-1 : idx-1.
//     right: if EXIT_LAST && idx==N_ITEMS-1 -> HALT; else -> GAME, game_sel=1<<idx, enter_pulse=1.
//     left and game_done ignored in MENU.
//   - GAME: game_done or evt_left (either or both) -> MENU, game_sel=0, idx = RETURN_TO_SEL ? idx : 0.
//     up/down/right ignored; menu_idx holds the active item.
//   - HALT: all inputs ignored until reset.
//   - Auto-repeat (REPEAT_DLY>0, MENU only): counter clears on any up/down edge, on release, when
//     both held, or when leaving MENU. Exactly one of up/down held: counter increments; reaching
//     REPEAT_DLY gives one step and reloads so the next step follows REPEAT_PER cycles later, and so on.
//     Repeat steps obey the same wrap rules. Counter saturates; width sized from max(DLY,PER).
//   - game_sel always one-hot or zero. enter_pulse never high two cycles running.
// TESTING
//   1 Reset, N_ITEMS=3: pulse btn_up -> menu_idx 2; btn_down x2 -> 0 then 1 (wrap both ways).
//   2 idx 1, pulse btn_right -> in_game=1, game_sel=3'b010, enter_pulse one cycle, state_output=4'b0101.
//   3 In GAME idx 1, up/down/right pulses -> no change; game_done -> in_game 0, menu_idx 1;
//     repeat with RETURN_TO_SEL=0 and btn_left -> menu_idx 0.
//   4 idx 2, btn_right with EXIT_LAST=1 -> halted=1, game_sel 0; any buttons -> no change until sys_rst_n low.
//   5 REPEAT_DLY=4, REPEAT_PER=2: hold btn_down 10 cycles from idx 0 -> steps at cycles 1, 5, 7, 9
//     (idx 1,2,0,1); up+down pressed together -> no step.
//   6 Assert sys_rst_n low mid-GAME asynchronously -> outputs at reset values immediately, no enter_pulse.

Source files
------------

// File: rtl/menu_nav_fsm.sv
// Menu controller: up/down navigation with wrap-around and optional auto-repeat.
// Right enters a game or the terminal EXIT entry; left or game_done returns to the menu.
module menu_nav_fsm #(
  parameter int N_ITEMS       = 3,
  parameter int EXIT_LAST     = 1,
  parameter int RETURN_TO_SEL = 1,
  parameter int REPEAT_DLY    = 0,
  parameter int REPEAT_PER    = 1,
  localparam int IDX_W        = $clog2(N_ITEMS)
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               game_done,
  output logic [IDX_W-1:0]   menu_idx,
  output logic               in_game,
  output logic               halted,
  output logic [N_ITEMS-1:0] game_sel,
  output logic               enter_pulse,
  output logic [IDX_W+1:0]   state_output
);

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITEMS - 1);
  localparam logic [CNT_W:0]   DLY_C    = (CNT_W+1)'(REPEAT_DLY);
  localparam logic [CNT_W:0]   PER_C    = (CNT_W+1)'(REPEAT_PER);

  typedef enum logic [1:0] {S_MENU, S_GAME, S_HALT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_ITEMS-1:0] game_sel_q, game_sel_d;
  logic               enter_q, enter_d;
  logic               in_game_q, in_game_d;
  logic               halted_q, halted_d;
  logic               up_q, down_q, left_q, right_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rphase_q, rphase_d;

  logic               evt_up, evt_down, evt_left, evt_right;
  logic               rep_up, rep_down, act_up, act_down;
  logic [CNT_W:0]     cnt_inc, thr;

  assign evt_up    = btn_up    & ~up_q;
  assign evt_down  = btn_down  & ~down_q;
  assign evt_left  = btn_left  & ~left_q;
  assign evt_right = btn_right & ~right_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_MENU;
      idx_q      <= '0;
      game_sel_q <= '0;
      enter_q    <= 1'b0;
      in_game_q  <= 1'b0;
      halted_q   <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      cnt_q      <= '0;
      rphase_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      game_sel_q <= game_sel_d;
      enter_q    <= enter_d;
      in_game_q  <= in_game_d;
      halted_q   <= halted_d;
      up_q       <= btn_up;
      down_q     <= btn_down;
      left_q     <= btn_left;
      right_q    <= btn_right;
      cnt_q      <= cnt_d;
      rphase_q   <= rphase_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    game_sel_d = game_sel_q;
    enter_d    = 1'b0;
    cnt_d      = '0;
    rphase_d   = 1'b0;
    rep_up     = 1'b0;
    rep_down   = 1'b0;
    act_up     = 1'b0;
    act_down   = 1'b0;
    cnt_inc    = {1'b0, cnt_q} + 1'b1;
    thr        = rphase_q ? PER_C : DLY_C;

    case (state_q)
      S_MENU: begin
        // Repeat runs only while exactly one direction is held with no fresh edge.
        if (REPEAT_DLY > 0 && !evt_up && !evt_down && (btn_up != btn_down)) begin
          if (cnt_inc >= thr) begin
            rep_up   = btn_up;
            rep_down = btn_down;
            rphase_d = 1'b1;
          end else begin
            cnt_d    = cnt_inc[CNT_W-1:0];
            rphase_d = rphase_q;
          end
        end
        act_down = (evt_down & ~evt_up) | rep_down;
        act_up   = (evt_up & ~evt_down) | rep_up;

        if (evt_up && evt_down) begin
          idx_d = idx_q;
        end else if (act_down) begin
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else if (act_up) begin
          idx_d = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
        end else if (evt_right) begin
          cnt_d    = '0;
          rphase_d = 1'b0;
          if (EXIT_LAST != 0 && idx_q == LAST_IDX) begin
            state_d = S_HALT;
          end else begin
            state_d    = S_GAME;
            game_sel_d = N_ITEMS'(1) << idx_q;
            enter_d    = 1'b1;
          end
        end
      end
      S_GAME: begin
        if (game_done || evt_left) begin
          state_d    = S_MENU;
          game_sel_d = '0;
          if (RETURN_TO_SEL == 0) idx_d = '0;
        end
      end
      default: begin
        state_d    = S_HALT;
        game_sel_d = '0;
      end
    endcase

    in_game_d = (state_d == S_GAME);
    halted_d  = (state_d == S_HALT);
  end

  assign menu_idx     = idx_q;
  assign in_game      = in_game_q;
  assign halted       = halted_q;
  assign game_sel     = game_sel_q;
  assign enter_pulse  = enter_q;
  assign state_output = {halted_q, in_game_q, idx_q};

endmodule

// File: tb/tb_menu_nav_fsm.sv
// Directed bench for menu_nav_fsm: a default instance plus one with
// return-to-item-0 and auto-repeat (delay 4, period 2).
module tb_menu_nav_fsm;

  logic       clk;
  logic       rst_n;
  int         checks;
  int         errors;

  logic       a_up, a_down, a_left, a_right, a_done;
  logic [1:0] a_idx;
  logic       a_in_game, a_halted, a_enter;
  logic [2:0] a_sel;
  logic [3:0] a_so;

  logic       b_up, b_down, b_left, b_right, b_done;
  logic [1:0] b_idx;
  logic       b_in_game, b_halted, b_enter;
  logic [2:0] b_sel;
  logic [3:0] b_so;

  menu_nav_fsm #(
    .N_ITEMS(3), .EXIT_LAST(1), .RETURN_TO_SEL(1), .REPEAT_DLY(0), .REPEAT_PER(1)
  ) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .btn_up(a_up), .btn_down(a_down), .btn_left(a_left), .btn_right(a_right),
    .game_done(a_done),
    .menu_idx(a_idx), .in_game(a_in_game), .halted(a_halted),
    .game_sel(a_sel), .enter_pulse(a_enter), .state_output(a_so)
  );

  menu_nav_fsm #(
    .N_ITEMS(3), .EXIT_LAST(1), .RETURN_TO_SEL(0), .REPEAT_DLY(4), .REPEAT_PER(2)
  ) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .btn_up(b_up), .btn_down(b_down), .btn_left(b_left), .btn_right(b_right),
    .game_done(b_done),
    .menu_idx(b_idx), .in_game(b_in_game), .halted(b_halted),
    .game_sel(b_sel), .enter_pulse(b_enter), .state_output(b_so)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] rep_exp [10];
    rep_exp = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
    checks = 0;
    errors = 0;
    {a_up, a_down, a_left, a_right, a_done} = '0;
    {b_up, b_down, b_left, b_right, b_done} = '0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_a_so", a_so, 4'b0000);
    chk("rst_a_sel", a_sel, 3'b000);
    chk("rst_a_enter", a_enter, 1'b0);
    chk("rst_b_so", b_so, 4'b0000);
    rst_n = 1'b1;
    tick();

    // Wrap both ways: up from 0 -> 2, down from 2 -> 0
    a_up = 1'b1; tick(); chk("up_wrap", a_idx, 2'd2);
    a_up = 1'b0; tick(); chk("up_release", a_idx, 2'd2);
    a_down = 1'b1; tick(); chk("down_wrap", a_idx, 2'd0);
    a_down = 1'b0; tick();
    // Held level steps once only (no repeat on instance a)
    a_down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("down_held", a_idx, 2'd1);
    end
    a_down = 1'b0; tick();
    a_up = 1'b1; a_down = 1'b1; tick(); chk("up_down_same", a_idx, 2'd1);
    a_up = 1'b0; a_down = 1'b0; tick(); chk("up_down_after", a_idx, 2'd1);

    // Enter game 1
    a_right = 1'b1; tick();
    chk("enter_so", a_so, 4'b0101);
    chk("enter_sel", a_sel, 3'b010);
    chk("enter_pulse", a_enter, 1'b1);
    a_right = 1'b0; tick();
    chk("enter_pulse_once", a_enter, 1'b0);
    chk("game_so", a_so, 4'b0101);

    // up/down/right ignored in GAME
    a_up = 1'b1; tick(); a_up = 1'b0; tick();
    a_down = 1'b1; tick(); a_down = 1'b0; tick();
    a_right = 1'b1; tick(); a_right = 1'b0; tick();
    chk("game_ign_so", a_so, 4'b0101);
    chk("game_ign_sel", a_sel, 3'b010);
    chk("game_ign_enter", a_enter, 1'b0);
    a_done = 1'b1; tick(); a_done = 1'b0;
    chk("done_so", a_so, 4'b0001);
    chk("done_sel", a_sel, 3'b000);
    tick();
    a_left = 1'b1; tick(); a_left = 1'b0; tick();
    chk("left_in_menu", a_so, 4'b0001);

    // Exit entry -> HALT, then everything ignored
    a_down = 1'b1; tick(); a_down = 1'b0; tick();
    chk("to_last", a_idx, 2'd2);
    a_right = 1'b1; tick();
    chk("halt_so", a_so, 4'b1010);
    chk("halt_sel", a_sel, 3'b000);
    chk("halt_enter", a_enter, 1'b0);
    a_right = 1'b0; tick();
    {a_up, a_down, a_left, a_right, a_done} = 5'b11111; tick();
    {a_up, a_down, a_left, a_right, a_done} = 5'b00000; tick();
    a_up = 1'b1; tick(); a_up = 1'b0; a_right = 1'b1; tick(); a_right = 1'b0; tick();
    chk("halt_hold", a_so, 4'b1010);

    // Async reset leaves HALT
    rst_n = 1'b0; #1;
    chk("rst_halt_so", a_so, 4'b0000);
    tick();
    rst_n = 1'b1; tick();

    // Async reset mid-GAME, sampled between clock edges
    a_right = 1'b1; tick();
    chk("game0_sel", a_sel, 3'b001);
    chk("game0_enter", a_enter, 1'b1);
    rst_n = 1'b0; #1;
    chk("rst_game_so", a_so, 4'b0000);
    chk("rst_game_sel", a_sel, 3'b000);
    chk("rst_game_enter", a_enter, 1'b0);
    a_right = 1'b0;
    tick();
    chk("rst_held_enter", a_enter, 1'b0);
    rst_n = 1'b1; tick();

    // Instance b: left from game returns to item 0
    b_down = 1'b1; tick(); b_down = 1'b0; tick();
    chk("b_idx1", b_idx, 2'd1);
    b_right = 1'b1; tick(); b_right = 1'b0;
    chk("b_game_sel", b_sel, 3'b010);
    tick();
    b_left = 1'b1; tick(); b_left = 1'b0;
    chk("b_left_so", b_so, 4'b0000);
    tick();

    // Auto-repeat: first step on the edge, then after 4, then every 2
    b_down = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); chk($sformatf("rep_down_c%0d", i + 1), b_idx, rep_exp[i]);
    end
    b_down = 1'b0; tick(); tick();
    chk("rep_release", b_idx, 2'd1);

    // Both pressed together and held: no step, no repeat
    b_up = 1'b1; b_down = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); chk("rep_both_held", b_idx, 2'd1);
    end
    b_up = 1'b0; b_down = 1'b0; tick();

    // Held up from 1: edge step to 0, repeat wraps to 2 at cycle 5
    b_up = 1'b1;
    tick(); chk("rep_up_c1", b_idx, 2'd0);
    tick(); tick(); tick();
    chk("rep_up_c4", b_idx, 2'd0);
    tick(); chk("rep_up_c5_wrap", b_idx, 2'd2);
    b_up = 1'b0; tick();
    chk("rep_up_release", b_so, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
